fifo_sc_rd_drain: RTL and testbench
===================================

Name: fifo_sc_rd_drain

Overview:
- Read-side companion to the team's single-clock register-based FIFO.
- Drives the FIFO's request-style read port (read request in; data returned RD_LAT cycles later with a valid strobe) and re-times the returned words into a valid/ready stream for downstream consumers.
- Guarantees no read on empty and no loss of returned data under downstream backpressure, using a small internal skid buffer sized by credits.
- Sits between the FIFO's read port and any valid/ready consumer.

Parameters:
- DATA_WD, 32, width of FIFO data and output data.
- RD_LAT, 1, FIFO read latency in cycles from read request to returned-data valid; legal values 1..2.
- BUF_DEPTH (localparam), RD_LAT+2, skid-buffer entries.
- BUF_WD (localparam), FUNC_LOG2(BUF_DEPTH)+1, width of occupancy counters.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- en_i  input  1  1 = issue reads; 0 = stop issuing, returns in flight still captured.
- fifo_ept_i  input  1  FIFO empty flag.
- fifo_rd_val_o  output  1  read request to FIFO, one word per cycle asserted.
- fifo_rd_val_i  input  1  FIFO returned-data valid.
- fifo_rd_dat_i  input  DATA_WD  FIFO returned data.
- out_val_o  output  1  output word valid.
- out_dat_o  output  DATA_WD  output word.
- out_rdy_i  input  1  downstream ready; transfer when out_val_o && out_rdy_i.
- idle_o  output  1  no word buffered and none in flight.
- err_o  output  1  sticky protocol error.

Behaviour:
- Reset: buffer pointers, buf_cnt, in-flight shift register and err_o all 0. fifo_rd_val_o=0, out_val_o=0, idle_o=1. out_dat_o is don't-care; buffer storage is not reset.
- In-flight tracking:
  - RD_LAT-bit shift register; bit 0 is loaded with fifo_rd_val_o each cycle.
  - exp_ret = MSB, meaning a return is expected this cycle.
  - infl_cnt = popcount of the shift register.
- Issue rule: fifo_rd_val_o = en_i && !fifo_ept_i && (buf_cnt + infl_cnt < BUF_DEPTH).
  - The rule is purely registered-state based; there is no combinational path from out_rdy_i.
  - The FIFO empty flag updates on the clock after a read, so consecutive-cycle issue is safe.
- Throughput: with out_rdy_i held at 1, sustained 1 word/cycle after an initial RD_LAT+1-cycle fill.
- Capture:
  - When fifo_rd_val_i=1, write fifo_rd_dat_i at wr_ptr and advance wr_ptr.
  - Pointers wrap from BUF_DEPTH-1 to 0 explicitly; BUF_DEPTH need not be a power of 2.
- Output:
  - out_val_o = (buf_cnt != 0); out_dat_o = buf[rd_ptr], a registered array read.
  - Pop when out_val_o && out_rdy_i; rd_ptr advances.
  - out_dat_o holds stable while out_val_o=1 and out_rdy_i=0.
- Occupancy:
  - buf_cnt += push - pop.
  - Simultaneous push and pop leaves buf_cnt unchanged; push into the full buffer while popping is legal.
- Ordering: output order equals FIFO read order; no reordering or drop.
- en_i deassert mid-stream: stop issuing next cycle. Already-requested words still return and are delivered. idle_o rises once buf_cnt=0 and infl_cnt=0.
- err_o is set, and stays set until reset, on either condition:
  - fifo_rd_val_i != exp_ret (unexpected or missing return).
  - push while buf_cnt==BUF_DEPTH and no pop (overflow; data dropped).
- idle_o = (buf_cnt==0) && (infl_cnt==0), combinational from registers.
- Reset asserted mid-operation:
  - All state clears immediately and outputs return to reset values asynchronously.
  - In-flight returns are lost. The FIFO shares the same reset, so no stale return can arrive.

Test Plan:
- Reset/idle: rstn low for 3 cycles, then high, fifo_ept_i=1, en_i=1 -> fifo_rd_val_o=0, out_val_o=0, idle_o=1, err_o=0 for 20 cycles.
- Streaming: FIFO model (RD_LAT=1) preloaded 0x1..0x10, out_rdy_i=1 -> out_dat_o 0x1..0x10 in order on 16 consecutive cycles, starting 2 cycles after first fifo_rd_val_o; idle_o=1 after the last word.
- Backpressure: 8 words, out_rdy_i=0 from cycle 0 -> fifo_rd_val_o asserted exactly 3 times then held 0. out_val_o=1 with out_dat_o stable at 0x1. Releasing out_rdy_i yields 0x1..0x8 in order, no loss, err_o=0.
- Random ready: 256 words, out_rdy_i random 50% -> scoreboard match, buf_cnt never exceeds 3, err_o=0. Repeat with RD_LAT=2 and check buf_cnt never exceeds 4.
- en_i drop mid-stream: drop en_i in the cycle after the 5th request -> no further requests, exactly 5 words delivered, idle_o=1 afterwards. Re-raising en_i resumes with word 6.
- Error injection: force fifo_rd_val_i=1 with no outstanding request -> err_o=1 next cycle and stays 1 until rstn pulse; rstn low mid-stream clears err_o, out_val_o and buffer immediately.

Source files
------------

// File: rtl/fifo_sc_rd_drain.sv
// Read-side drain for the single-clock FIFO: issues credit-limited read requests and
// re-times the latency-delayed returns into a valid/ready stream through a small skid buffer.
module fifo_sc_rd_drain #(
  parameter int DATA_WD = 32,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en_i,
  input  logic               fifo_ept_i,
  output logic               fifo_rd_val_o,
  input  logic               fifo_rd_val_i,
  input  logic [DATA_WD-1:0] fifo_rd_dat_i,
  output logic               out_val_o,
  output logic [DATA_WD-1:0] out_dat_o,
  input  logic               out_rdy_i,
  output logic               idle_o,
  output logic               err_o
);

  localparam int BUF_DEPTH = RD_LAT + 2;
  localparam int BUF_WD    = $clog2(BUF_DEPTH) + 1;
  localparam int PTR_WD    = $clog2(BUF_DEPTH);

  localparam logic [BUF_WD-1:0] DEPTH_C  = BUF_WD'(BUF_DEPTH);
  localparam logic [PTR_WD-1:0] LAST_PTR = PTR_WD'(BUF_DEPTH - 1);

  logic [RD_LAT-1:0]  r_infl;
  logic [BUF_WD-1:0]  r_buf_cnt;
  logic [PTR_WD-1:0]  r_wr_ptr;
  logic [PTR_WD-1:0]  r_rd_ptr;
  logic               r_err;
  logic [DATA_WD-1:0] r_buf [BUF_DEPTH];

  logic [BUF_WD-1:0]  w_infl_cnt;
  logic [BUF_WD:0]    w_occ;
  logic               w_exp_ret;
  logic               w_rd_req;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_ovf;
  logic               w_wr_en;

  function automatic logic [PTR_WD-1:0] next_ptr(input logic [PTR_WD-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every variable driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_infl_cnt = w_infl_cnt + BUF_WD'(r_infl[i]);
    end
  end

  assign w_exp_ret = r_infl[RD_LAT-1];
  assign w_occ     = {1'b0, r_buf_cnt} + {1'b0, w_infl_cnt};

  // Credits count both buffered words and words still in flight, so a return always has a slot.
  assign w_rd_req  = rstn && en_i && !fifo_ept_i && (w_occ < {1'b0, DEPTH_C});

  assign w_full    = (r_buf_cnt == DEPTH_C);
  assign w_push    = fifo_rd_val_i;
  assign w_pop     = out_val_o && out_rdy_i;
  assign w_ovf     = w_push && w_full && !w_pop;
  assign w_wr_en   = w_push && !w_ovf;

  assign fifo_rd_val_o = w_rd_req;
  assign out_val_o     = (r_buf_cnt != '0);
  assign out_dat_o     = r_buf[r_rd_ptr];
  assign idle_o        = (r_buf_cnt == '0) && (w_infl_cnt == '0);
  assign err_o         = r_err;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_infl    <= '0;
      r_buf_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_err     <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_infl[i] <= r_infl[i-1];
      end
      r_infl[0] <= w_rd_req;

      if (w_wr_en) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end

      if (w_wr_en && !w_pop) begin
        r_buf_cnt <= r_buf_cnt + 1'b1;
      end else if (!w_wr_en && w_pop) begin
        r_buf_cnt <= r_buf_cnt - 1'b1;
      end

      if ((fifo_rd_val_i != w_exp_ret) || w_ovf) begin
        r_err <= 1'b1;
      end
    end
  end

  // NOTE: buffer storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_ptr] <= fifo_rd_dat_i;
    end
  end

endmodule

// File: tb/tb_fifo_sc_rd_drain.sv
// Bench for fifo_sc_rd_drain: two instances (RD_LAT=1 and RD_LAT=2) share stimulus, each fed by
// its own FIFO model returning sequential words; a monitor pops a per-lane expectation queue.
module tb_fifo_sc_rd_drain;

  localparam int DW = 32;

  logic          clk;
  logic          rstn;
  logic          en;
  logic          rdy;
  logic          inj;
  int            total;

  logic [1:0]    rd_req;
  logic [1:0]    ept;
  logic [1:0]    rd_val;
  logic [1:0]    out_val;
  logic [1:0]    idle;
  logic [1:0]    err;
  logic [DW-1:0] rd_dat  [2];
  logic [DW-1:0] out_dat [2];

  int            nxt [2];
  logic          pv  [2][2];
  logic [DW-1:0] pd  [2][2];

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out [2] = '{default: 0};
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_sc_rd_drain #(.DATA_WD(DW), .RD_LAT(1)) dut0 (
    .clk(clk), .rstn(rstn), .en_i(en), .fifo_ept_i(ept[0]),
    .fifo_rd_val_o(rd_req[0]), .fifo_rd_val_i(rd_val[0]), .fifo_rd_dat_i(rd_dat[0]),
    .out_val_o(out_val[0]), .out_dat_o(out_dat[0]), .out_rdy_i(rdy),
    .idle_o(idle[0]), .err_o(err[0])
  );

  fifo_sc_rd_drain #(.DATA_WD(DW), .RD_LAT(2)) dut1 (
    .clk(clk), .rstn(rstn), .en_i(en), .fifo_ept_i(ept[1]),
    .fifo_rd_val_o(rd_req[1]), .fifo_rd_val_i(rd_val[1]), .fifo_rd_dat_i(rd_dat[1]),
    .out_val_o(out_val[1]), .out_dat_o(out_dat[1]), .out_rdy_i(rdy),
    .idle_o(idle[1]), .err_o(err[1])
  );

  // FIFO model: word n is the value n; the first `total` words are available after reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        nxt[k]   <= 1;
        pv[k][0] <= 1'b0;
        pv[k][1] <= 1'b0;
        pd[k][0] <= '0;
        pd[k][1] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        pv[k][0] <= rd_req[k];
        pd[k][0] <= DW'(nxt[k]);
        pv[k][1] <= pv[k][0];
        pd[k][1] <= pd[k][0];
        if (rd_req[k]) nxt[k] <= nxt[k] + 1;
      end
    end
  end

  always_comb begin
    ept = '0;
    for (int k = 0; k < 2; k++) ept[k] = (nxt[k] > total);
  end

  assign rd_val[0] = pv[0][0] | inj;
  assign rd_dat[0] = pd[0][0];
  assign rd_val[1] = pv[1][1] | inj;
  assign rd_dat[1] = pd[1][1];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input int k, input logic [DW-1:0] got);
    logic [DW-1:0] e;
    bit            have;
    e    = '0;
    have = 1'b0;
    if (k == 0) begin
      have = (exp_q0.size() != 0);
      if (have) e = exp_q0.pop_front();
    end else begin
      have = (exp_q1.size() != 0);
      if (have) e = exp_q1.pop_front();
    end
    n_tests++;
    if (!have) begin
      n_fail++;
      $display("FAIL sb_unexpected lane%0d got=%0h expected=none", k, got);
    end else if (got !== e) begin
      n_fail++;
      $display("FAIL sb_data lane%0d got=%0h expected=%0h", k, got, e);
    end
  endtask

  // Monitor: every handshake pops the lane's queue; a request on an empty FIFO is a failure.
  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < 2; k++) begin
        if (out_val[k] && rdy) begin
          n_out[k]++;
          sb_pop(k, out_dat[k]);
        end
        if (rd_req[k] && ept[k]) check($sformatf("rd_on_empty_lane%0d", k), 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    total = n;
    for (int i = 1; i <= n; i++) begin
      exp_q0.push_back(DW'(i));
      exp_q1.push_back(DW'(i));
    end
  endtask

  task automatic do_reset();
    tick();
    rstn  = 1'b0;
    total = 0;
    exp_q0.delete();
    exp_q1.delete();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle == 2'b11 && exp_q0.size() == 0 && exp_q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  nreq0, nreq1, cnt, base0, base1, max0, max1;
    bit  seen, done;

    rstn  = 1'b1;
    en    = 1'b0;
    rdy   = 1'b0;
    inj   = 1'b0;
    total = 0;
    #1;
    rstn = 1'b0;
    en   = 1'b1;
    rdy  = 1'b1;

    // Reset / idle with an empty FIFO
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("reset_idle", {rd_req, out_val, idle, err}, 8'b00_00_11_00);
    end

    // Streaming 0x1..0x10 with out_rdy_i held high
    tick();
    en = 1'b0;
    load(16);
    tick();
    en   = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_req[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("stream_first_req", seen, 1);
    repeat (2) @(negedge clk);
    for (int w = 1; w <= 16; w++) begin
      check($sformatf("stream_word%0d", w), {out_val[0], out_dat[0]}, {1'b1, DW'(w)});
      @(negedge clk);
    end
    check("stream_idle", idle[0], 1);
    wait_drain(20, "stream_drain");

    // Backpressure from the start: credits cap the requests
    en = 1'b0;
    do_reset();
    rdy = 1'b0;
    load(8);
    en    = 1'b1;
    nreq0 = 0;
    nreq1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      nreq0 += int'(rd_req[0]);
      nreq1 += int'(rd_req[1]);
      if (c >= 4) check("bp_hold", {out_val[0], out_dat[0]}, {1'b1, 32'h1});
    end
    check("bp_req_lat1", nreq0, 3);
    check("bp_req_lat2", nreq1, 4);
    tick();
    rdy = 1'b1;
    wait_drain(40, "bp_drain");
    check("bp_err", err, 2'b00);

    // Random ready over 256 words
    en = 1'b0;
    do_reset();
    load(256);
    en   = 1'b1;
    max0 = 0;
    max1 = 0;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (int'(dut0.r_buf_cnt) > max0) max0 = int'(dut0.r_buf_cnt);
      if (int'(dut1.r_buf_cnt) > max1) max1 = int'(dut1.r_buf_cnt);
      if (idle == 2'b11 && exp_q0.size() == 0 && exp_q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("rand_done", done, 1);
    check("rand_max_lat1_le3", (max0 <= 3), 1);
    check("rand_max_lat2_le4", (max1 <= 4), 1);
    check("rand_err", err, 2'b00);

    // en_i drop after the 5th request, then resume
    tick();
    rdy = 1'b1;
    en  = 1'b0;
    do_reset();
    load(20);
    base0 = n_out[0];
    base1 = n_out[1];
    en    = 1'b1;
    cnt   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_req[0]) cnt++;
      if (cnt == 5) break;
    end
    check("endrop_5req", cnt, 5);
    @(posedge clk);
    #1 en = 1'b0;
    nreq0 = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      nreq0 += int'(rd_req[0]) + int'(rd_req[1]);
    end
    check("endrop_noreq", nreq0, 0);
    check("endrop_deliv_lat1", n_out[0] - base0, 5);
    check("endrop_deliv_lat2", n_out[1] - base1, 5);
    check("endrop_idle", idle, 2'b11);
    tick();
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_val[0]) break;
    end
    check("endrop_word6", {out_val[0], out_dat[0]}, {1'b1, 32'h6});
    wait_drain(60, "endrop_resume_drain");
    check("endrop_total_lat1", n_out[0] - base0, 20);
    check("endrop_total_lat2", n_out[1] - base1, 20);

    // Error injection: a return with nothing in flight
    en = 1'b0;
    do_reset();
    rdy = 1'b0;
    @(negedge clk);
    check("err_clear", err, 2'b00);
    tick();
    inj = 1'b1;
    @(negedge clk);
    check("err_pre", err, 2'b00);
    tick();
    inj = 1'b0;
    @(negedge clk);
    check("err_set", err, 2'b11);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 2'b11);

    // Reset asserted mid-stream clears everything asynchronously
    tick();
    load(10);
    en = 1'b1;
    repeat (6) tick();
    check("pre_rst_val", out_val, 2'b11);
    #2 rstn = 1'b0;
    #1 check("rst_async", {err, out_val, idle, rd_req}, 8'b00_00_11_00);
    exp_q0.delete();
    exp_q1.delete();
    load(4);
    tick();
    tick();
    rstn = 1'b1;
    rdy  = 1'b1;
    wait_drain(40, "rst_restream_drain");
    check("rst_restream_err", err, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
